// File: rtl/lock_arbiter.sv
// Hardware lock service for the OmpSs manager: decodes lock/unlock commands,
// tracks per-lock busy/owner state and returns an ack word for each lock request.
module lock_arbiter #(
  parameter int LOCK_ID_BITS = 8,
  parameter int ACC_BITS     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             inStream_tdata,
  input  logic                    inStream_tvalid,
  output logic                    inStream_tready,
  input  logic [ACC_BITS-1:0]     inStream_tid,
  output logic [63:0]             outStream_tdata,
  output logic                    outStream_tvalid,
  input  logic                    outStream_tready,
  output logic [ACC_BITS-1:0]     outStream_tdest,
  output logic [4:0]              outStream_tid,
  output logic [LOCK_ID_BITS:0]   locked_count,
  output logic                    bad_cmd,
  output logic                    bad_unlock
);

  localparam int         NUM_LOCKS       = 2 ** LOCK_ID_BITS;
  localparam logic [7:0] CMD_LOCK        = 8'h04;
  localparam logic [7:0] CMD_UNLOCK      = 8'h06;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam logic [4:0] HWR_LOCK_ID     = 5'h15;

  typedef enum logic [1:0] {IDLE, DECODE, ACK} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [7:0]              r_code;
  logic [LOCK_ID_BITS-1:0] r_lockId;
  logic [ACC_BITS-1:0]     r_tid;
  logic [NUM_LOCKS-1:0]    r_busy;
  logic [ACC_BITS-1:0]     r_owner [NUM_LOCKS];
  logic [LOCK_ID_BITS:0]   r_count;
  logic [63:0]             r_ackData;
  logic [ACC_BITS-1:0]     r_ackDest;
  logic                    r_badCmd;
  logic                    r_badUnlock;

  logic                    w_accept;
  logic                    w_busy;
  logic                    w_ownerMatch;
  logic                    w_setBusy;
  logic                    w_clrBusy;
  logic                    w_loadAck;
  logic                    w_ackOk;
  logic                    w_badCmd;
  logic                    w_badUnlock;
  logic [7:0]              w_ackId;

  // Gating with rst keeps the input closed while reset is held
  assign inStream_tready  = (r_state == IDLE) && !rst;
  assign w_accept         = inStream_tvalid && inStream_tready;
  assign w_busy           = r_busy[r_lockId];
  assign w_ownerMatch     = (r_owner[r_lockId] == r_tid);
  assign outStream_tvalid = (r_state == ACK);
  assign outStream_tdata  = r_ackData;
  assign outStream_tdest  = r_ackDest;
  assign outStream_tid    = HWR_LOCK_ID;
  assign locked_count     = r_count;
  assign bad_cmd          = r_badCmd;
  assign bad_unlock       = r_badUnlock;

  always_comb begin
    w_ackId = '0;
    w_ackId[LOCK_ID_BITS-1:0] = r_lockId;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_setBusy   = 1'b0;
    w_clrBusy   = 1'b0;
    w_loadAck   = 1'b0;
    w_ackOk     = 1'b0;
    w_badCmd    = 1'b0;
    w_badUnlock = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = DECODE;
      end
      DECODE: begin
        w_nextState = IDLE;
        if (r_code == CMD_LOCK) begin
          w_loadAck   = 1'b1;
          w_nextState = ACK;
          if (!w_busy) begin
            w_setBusy = 1'b1;
            w_ackOk   = 1'b1;
          end else if (w_ownerMatch) begin
            w_ackOk = 1'b1;
          end
        end else if (r_code == CMD_UNLOCK) begin
          if (w_busy && w_ownerMatch) w_clrBusy   = 1'b1;
          else                        w_badUnlock = 1'b1;
        end else begin
          w_badCmd = 1'b1;
        end
      end
      ACK: begin
        if (outStream_tready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code   <= '0;
      r_lockId <= '0;
      r_tid    <= '0;
    end else if (w_accept) begin
      r_code   <= inStream_tdata[7:0];
      r_lockId <= inStream_tdata[8 +: LOCK_ID_BITS];
      r_tid    <= inStream_tid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else if (w_setBusy) begin
      r_busy[r_lockId] <= 1'b1;
      r_count          <= r_count + {{LOCK_ID_BITS{1'b0}}, 1'b1};
    end else if (w_clrBusy) begin
      r_busy[r_lockId] <= 1'b0;
      r_count          <= r_count - {{LOCK_ID_BITS{1'b0}}, 1'b1};
    end
  end

  // Owner entries are only meaningful while the matching busy bit is set
  always_ff @(posedge clk) begin
    if (w_setBusy) r_owner[r_lockId] <= r_tid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ackData   <= '0;
      r_ackDest   <= '0;
      r_badCmd    <= 1'b0;
      r_badUnlock <= 1'b0;
    end else begin
      r_badCmd    <= w_badCmd;
      r_badUnlock <= w_badUnlock;
      if (w_loadAck) begin
        r_ackData <= {48'h0, w_ackId, (w_ackOk ? ACK_OK_CODE : ACK_REJECT_CODE)};
        r_ackDest <= r_tid;
      end
    end
  end

endmodule

// File: tb/tb_lock_arbiter.sv
// Directed bench for lock_arbiter: lock/contention/unlock rules, backpressure,
// unknown commands and asynchronous reset with a pending ack.
module tb_lock_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inStream_tdata = '0;
  logic        inStream_tvalid = 1'b0;
  logic        inStream_tready;
  logic [7:0]  inStream_tid = '0;
  logic [63:0] outStream_tdata;
  logic        outStream_tvalid;
  logic        outStream_tready = 1'b0;
  logic [7:0]  outStream_tdest;
  logic [4:0]  outStream_tid;
  logic [8:0]  locked_count;
  logic        bad_cmd;
  logic        bad_unlock;

  int compared   = 0;
  int mismatched = 0;

  lock_arbiter #(.LOCK_ID_BITS(8), .ACC_BITS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .inStream_tdata   (inStream_tdata),
    .inStream_tvalid  (inStream_tvalid),
    .inStream_tready  (inStream_tready),
    .inStream_tid     (inStream_tid),
    .outStream_tdata  (outStream_tdata),
    .outStream_tvalid (outStream_tvalid),
    .outStream_tready (outStream_tready),
    .outStream_tdest  (outStream_tdest),
    .outStream_tid    (outStream_tid),
    .locked_count     (locked_count),
    .bad_cmd          (bad_cmd),
    .bad_unlock       (bad_unlock)
  );

  always #5 clk = ~clk;

  // Global watchdog so a stuck handshake still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers a command at a negedge; returns at the negedge of the DECODE cycle (N+1)
  task automatic applyStimulus(input logic [7:0] tid, input logic [63:0] data);
    int guard = 0;
    @(negedge clk);
    inStream_tid    = tid;
    inStream_tdata  = data;
    inStream_tvalid = 1'b1;
    while (!inStream_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("accept_timeout", {63'h0, inStream_tready}, 64'h1);
    @(negedge clk);
    inStream_tvalid = 1'b0;
  endtask

  // Completes the ack visible at the current negedge
  task automatic ackHandshake();
    outStream_tready = 1'b1;
    @(negedge clk);
    outStream_tready = 1'b0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    checkOutput("rst_in_tready",  {63'h0, inStream_tready}, 64'h0);
    checkOutput("rst_out_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("rst_out_tdata",  outStream_tdata, 64'h0);
    checkOutput("rst_out_tdest",  {56'h0, outStream_tdest}, 64'h0);
    checkOutput("rst_out_tid",    {59'h0, outStream_tid}, 64'h15);
    checkOutput("rst_count",      {55'h0, locked_count}, 64'h0);
    checkOutput("rst_bad",        {62'h0, bad_cmd, bad_unlock}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release_in_tready", {63'h0, inStream_tready}, 64'h1);

    // Lock free: tid 3 takes lock 5
    applyStimulus(8'd3, 64'h0504);
    checkOutput("lock_n1_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("lock_n1_tready", {63'h0, inStream_tready}, 64'h0);
    checkOutput("lock_n1_count",  {55'h0, locked_count}, 64'h0);
    @(negedge clk);
    checkOutput("lock_n2_tvalid", {63'h0, outStream_tvalid}, 64'h1);
    checkOutput("lock_n2_tdata",  outStream_tdata, 64'h0501);
    checkOutput("lock_n2_tdest",  {56'h0, outStream_tdest}, 64'h3);
    checkOutput("lock_n2_count",  {55'h0, locked_count}, 64'h1);
    checkOutput("lock_n2_tready", {63'h0, inStream_tready}, 64'h0);
    ackHandshake();
    checkOutput("lock_done_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("lock_done_tready", {63'h0, inStream_tready}, 64'h1);

    // Contention: tid 7 is rejected
    applyStimulus(8'd7, 64'h0504);
    @(negedge clk);
    checkOutput("contend_tdata", outStream_tdata, 64'h0500);
    checkOutput("contend_tdest", {56'h0, outStream_tdest}, 64'h7);
    checkOutput("contend_count", {55'h0, locked_count}, 64'h1);
    ackHandshake();

    // Re-lock by the owner is acknowledged without a count change
    applyStimulus(8'd3, 64'h0504);
    @(negedge clk);
    checkOutput("relock_tdata", outStream_tdata, 64'h0501);
    checkOutput("relock_count", {55'h0, locked_count}, 64'h1);
    ackHandshake();

    // Unlock by non-owner
    applyStimulus(8'd7, 64'h0506);
    checkOutput("badunl_n1", {63'h0, bad_unlock}, 64'h0);
    @(negedge clk);
    checkOutput("badunl_n2_pulse",  {63'h0, bad_unlock}, 64'h1);
    checkOutput("badunl_n2_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("badunl_n2_tready", {63'h0, inStream_tready}, 64'h1);
    checkOutput("badunl_n2_count",  {55'h0, locked_count}, 64'h1);
    @(negedge clk);
    checkOutput("badunl_n3_pulse",  {63'h0, bad_unlock}, 64'h0);

    // Unlock by owner
    applyStimulus(8'd3, 64'h0506);
    @(negedge clk);
    checkOutput("unlock_count",  {55'h0, locked_count}, 64'h0);
    checkOutput("unlock_bad",    {63'h0, bad_unlock}, 64'h0);
    checkOutput("unlock_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("unlock_tready", {63'h0, inStream_tready}, 64'h1);

    // tid 7 now acquires lock 5, then the ack is backpressured
    applyStimulus(8'd7, 64'h0504);
    @(negedge clk);
    checkOutput("relock7_tdata", outStream_tdata, 64'h0501);
    checkOutput("relock7_tdest", {56'h0, outStream_tdest}, 64'h7);
    inStream_tid    = 8'd3;
    inStream_tdata  = 64'h0504;
    inStream_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_tvalid",    {63'h0, outStream_tvalid}, 64'h1);
      checkOutput("bp_tdata",     outStream_tdata, 64'h0501);
      checkOutput("bp_tdest",     {56'h0, outStream_tdest}, 64'h7);
      checkOutput("bp_in_tready", {63'h0, inStream_tready}, 64'h0);
    end
    ackHandshake();
    checkOutput("bp_after_tvalid",   {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("bp_after_in_ready", {63'h0, inStream_tready}, 64'h1);
    @(negedge clk);
    inStream_tvalid = 1'b0;
    checkOutput("held_decode_ready", {63'h0, inStream_tready}, 64'h0);
    @(negedge clk);
    checkOutput("held_tvalid", {63'h0, outStream_tvalid}, 64'h1);
    checkOutput("held_tdata",  outStream_tdata, 64'h0500);
    checkOutput("held_tdest",  {56'h0, outStream_tdest}, 64'h3);
    ackHandshake();

    // Unknown command code
    applyStimulus(8'd5, 64'h0107);
    checkOutput("badcmd_n1", {63'h0, bad_cmd}, 64'h0);
    @(negedge clk);
    checkOutput("badcmd_n2_pulse",  {63'h0, bad_cmd}, 64'h1);
    checkOutput("badcmd_n2_tready", {63'h0, inStream_tready}, 64'h1);
    checkOutput("badcmd_n2_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("badcmd_n2_count",  {55'h0, locked_count}, 64'h1);
    @(negedge clk);
    checkOutput("badcmd_n3_pulse",  {63'h0, bad_cmd}, 64'h0);

    // Hold locks 0x00 and 0xFF, then reset while the 0xFF ack is pending
    applyStimulus(8'd1, 64'h0004);
    @(negedge clk);
    checkOutput("lock00_tdata", outStream_tdata, 64'h0001);
    ackHandshake();
    applyStimulus(8'd2, 64'hFF04);
    @(negedge clk);
    checkOutput("lockFF_tdata", outStream_tdata, 64'hFF01);
    checkOutput("lockFF_count", {55'h0, locked_count}, 64'h3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_tvalid", {63'h0, outStream_tvalid}, 64'h0);
    checkOutput("arst_tdata",  outStream_tdata, 64'h0);
    checkOutput("arst_tdest",  {56'h0, outStream_tdest}, 64'h0);
    checkOutput("arst_count",  {55'h0, locked_count}, 64'h0);
    checkOutput("arst_tready", {63'h0, inStream_tready}, 64'h0);
    checkOutput("arst_tid",    {59'h0, outStream_tid}, 64'h15);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rerelease_tready", {63'h0, inStream_tready}, 64'h1);

    // After reset, lock 0xFF is free again
    applyStimulus(8'd9, 64'hFF04);
    @(negedge clk);
    checkOutput("post_rst_tdata", outStream_tdata, 64'hFF01);
    checkOutput("post_rst_tdest", {56'h0, outStream_tdest}, 64'h9);
    checkOutput("post_rst_count", {55'h0, locked_count}, 64'h1);
    ackHandshake();
    applyStimulus(8'd4, 64'h0004);
    @(negedge clk);
    checkOutput("post_rst_lock00", outStream_tdata, 64'h0001);
    checkOutput("post_rst_count2", {55'h0, locked_count}, 64'h2);
    ackHandshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lock_arbiter.md
Name: lock_arbiter

Overview:
- Hardware lock service behind the HWR_LOCK_ID (5'h15) hardware-runtime port of the OmpSs manager.
- Consumes lock and unlock command words that accelerators send over a 64-bit stream.
- Keeps a per-lock busy bit and owner table, and returns one acknowledge word per lock request, routed back to the requesting accelerator.

Parameters:
- LOCK_ID_BITS, 8, width of lock identifier; NUM_LOCKS = 2**LOCK_ID_BITS.
- ACC_BITS, 8, width of accelerator id carried on tid/tdest.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- inStream_tdata  in  64  command word
- inStream_tvalid  in  1  command valid
- inStream_tready  out  1  command accepted
- inStream_tid  in  ACC_BITS  requesting accelerator id
- outStream_tdata  out  64  acknowledge word
- outStream_tvalid  out  1  ack valid
- outStream_tready  in  1  ack accepted
- outStream_tdest  out  ACC_BITS  destination accelerator (= requester)
- outStream_tid  out  5  constant HWR_LOCK_ID 5'h15
- locked_count  out  LOCK_ID_BITS+1  number of currently held locks
- bad_cmd  out  1  one-cycle pulse on unknown command code
- bad_unlock  out  1  one-cycle pulse on unlock of free lock or by non-owner

Behaviour:
- One clock; reset is asynchronous and active-high, port rst, clock port clk.
- Command decode:
  - tdata[7:0] = command code: 8'h04 lock, 8'h06 unlock.
  - tdata[15:8] = lock id; only the low LOCK_ID_BITS bits are used.
  - Other bits are ignored.
- Ack word:
  - [7:0] = ACK_OK_CODE 8'h01 (acquired) or ACK_REJECT_CODE 8'h00 (held by another accelerator).
  - [15:8] = lock id.
  - [63:16] = 0.
- State storage: busy[NUM_LOCKS] and owner[NUM_LOCKS] (ACC_BITS each).
- FSM states:
  - IDLE
    - inStream_tready=1.
    - On tvalid&tready: latch tdata and tid, go DECODE.
  - DECODE (1 cycle), by command code:
    - lock, busy=0: set busy, owner:=tid, increment count, ack OK, go ACK.
    - lock, busy=1 and owner==tid (re-lock by owner): ack OK, no state change, go ACK.
    - lock, busy=1 and owner!=tid: ack REJECT, go ACK.
    - unlock, busy=1 and owner==tid: clear busy, decrement count, go IDLE. Unlock produces no ack.
    - unlock, otherwise: pulse bad_unlock, no state change, go IDLE.
    - any other code: pulse bad_cmd, go IDLE.
  - ACK
    - outStream_tvalid=1; tdata, tdest and tid held stable until outStream_tready.
    - On handshake go IDLE.
    - inStream_tready=0 throughout.
- Latency:
  - Command handshake in cycle N.
  - Lock/unlock table update visible at the end of cycle N+1.
  - Ack tvalid asserted in cycle N+2 at the earliest.
  - Next command can be accepted in the cycle after the ack handshake, or N+2 for unlock.
- inStream_tready is low in DECODE and ACK; at most one command is in flight.
- locked_count:
  - Saturation is impossible by construction (max NUM_LOCKS).
  - Width LOCK_ID_BITS+1 so that 256 is representable.
- bad_cmd and bad_unlock are registered, high for exactly one cycle (the DECODE cycle + 1).
- Reset (including mid-ack):
  - All busy bits clear; locked_count=0; FSM to IDLE.
  - outStream_tvalid=0, outStream_tdata=0, outStream_tdest=0.
  - inStream_tready=0 during reset, 1 in the first cycle after release.
  - bad_cmd=0, bad_unlock=0.
  - The pending ack is discarded.
  - Owner contents need not be reset: they are qualified by busy.
- outStream_tid is constant 5'h15 at all times, including reset.

Test Plan:
- Lock free: tid=3, tdata=0x0504 -> ack tdata=0x0501, tdest=3, tvalid at N+2; locked_count=1.
- Contention: after the above, tid=7 sends 0x0504 -> ack 0x0500, tdest=7; owner stays 3; count stays 1.
- Unlock rules:
  - tid=7 sends unlock 0x0506 -> bad_unlock pulse, no ack, lock 5 still busy.
  - tid=3 sends 0x0506 -> count=0.
  - tid=7 then locks 0x0504 -> ack 0x0501.
- Backpressure: outStream_tready low for 5 cycles during ack -> tvalid and data stable, inStream_tready=0; a held tvalid command is accepted only after the ack handshake.
- Unknown code: tdata=0x0107 -> bad_cmd one-cycle pulse, no ack, no table change, tready back high at N+2.
- Reset:
  - Lock ids 0x00 and 0xFF held, ack pending; assert rst asynchronously -> tvalid drops immediately, count=0.
  - After release, tid=9 locking 0xFF -> ack 0xFF01.
